// File: rtl/uart_reg_bridge.sv
// Command responder behind the 8-bit UART: decodes 'W' addr data / 'R' addr frames into
// one-cycle register strobes and returns exactly one reply byte per command.
module uart_reg_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 32'd1000000,
   parameter logic [7:0]  OP_WRITE       = 8'h57,
   parameter logic [7:0]  OP_READ        = 8'h52
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxDone,
   input  logic       rxErr,
   input  logic [7:0] rxData,
   input  logic       txBusy,
   output logic       txStart,
   output logic [7:0] txData,
   output logic       regWe,
   output logic       regRe,
   output logic [7:0] regAddr,
   output logic [7:0] regWdata,
   input  logic [7:0] regRdata,
   output logic       frameErr,
   output logic       busy
);
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 32'sd21) ? $clog2(TIMEOUT_CYCLES) : 32'sd21;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [7:0] REPLY_OK     = 8'h4B;
   localparam logic [7:0] REPLY_BAD_OP = 8'h3F;
   localparam logic [7:0] REPLY_ERR    = 8'h45;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_GET_ADDR  = 4'd1,
      ST_GET_DATA  = 4'd2,
      ST_DO_WRITE  = 4'd3,
      ST_DO_READ   = 4'd4,
      ST_READ_WAIT = 4'd5,
      ST_SEND      = 4'd6,
      ST_TX_ACCEPT = 4'd7,
      ST_TX_DRAIN  = 4'd8
   } state_t;

   state_t           state_r, state_nx;
   logic             rx_prev_r;
   logic [CNT_W-1:0] cnt_r;
   logic             is_write_r, is_write_nx;
   logic [7:0]       addr_r, addr_nx;
   logic [7:0]       wdata_r, wdata_nx;
   logic [7:0]       reply_r, reply_nx;
   logic             we_r, re_r, ferr_r, busy_r, ferr_nx;
   logic             byte_ev_s, waiting_s, timeout_s;

   // The edge register resets high so a strobe already up at reset release is not a byte.
   assign byte_ev_s = rxDone & ~rx_prev_r;
   assign waiting_s = (state_r == ST_GET_ADDR) || (state_r == ST_GET_DATA);
   assign timeout_s = (cnt_r >= CNT_LAST);

   // Next-state and frame-decode logic.
   always_comb begin
      state_nx    = state_r;
      is_write_nx = is_write_r;
      addr_nx     = addr_r;
      wdata_nx    = wdata_r;
      reply_nx    = reply_r;
      ferr_nx     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (byte_ev_s && rxErr) begin
               ferr_nx  = 1'b1;
               reply_nx = REPLY_ERR;
               state_nx = ST_SEND;
            end else if (byte_ev_s && ((rxData == OP_WRITE) || (rxData == OP_READ))) begin
               is_write_nx = (rxData == OP_WRITE);
               state_nx    = ST_GET_ADDR;
            end else if (byte_ev_s) begin
               reply_nx = REPLY_BAD_OP;
               state_nx = ST_SEND;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_GET_ADDR: begin
            if (byte_ev_s && rxErr) begin
               ferr_nx  = 1'b1;
               reply_nx = REPLY_ERR;
               state_nx = ST_SEND;
            end else if (byte_ev_s) begin
               addr_nx  = rxData;
               state_nx = is_write_r ? ST_GET_DATA : ST_DO_READ;
            end else if (timeout_s) begin
               ferr_nx  = 1'b1;
               state_nx = ST_IDLE;
            end else begin
               state_nx = ST_GET_ADDR;
            end
         end
         ST_GET_DATA: begin
            if (byte_ev_s && rxErr) begin
               ferr_nx  = 1'b1;
               reply_nx = REPLY_ERR;
               state_nx = ST_SEND;
            end else if (byte_ev_s) begin
               wdata_nx = rxData;
               state_nx = ST_DO_WRITE;
            end else if (timeout_s) begin
               ferr_nx  = 1'b1;
               state_nx = ST_IDLE;
            end else begin
               state_nx = ST_GET_DATA;
            end
         end
         ST_DO_WRITE: begin
            reply_nx = REPLY_OK;
            state_nx = ST_SEND;
         end
         ST_DO_READ:   state_nx = ST_READ_WAIT;
         ST_READ_WAIT: begin
            reply_nx = regRdata;
            state_nx = ST_SEND;
         end
         ST_SEND: begin
            if (!txBusy) state_nx = ST_TX_ACCEPT;
            else         state_nx = ST_SEND;
         end
         ST_TX_ACCEPT: begin
            if (txBusy) state_nx = ST_TX_DRAIN;
            else        state_nx = ST_TX_ACCEPT;
         end
         ST_TX_DRAIN: begin
            if (!txBusy) state_nx = ST_IDLE;
            else         state_nx = ST_TX_DRAIN;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // State, frame fields and strobe outputs registered from the next-state decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         rx_prev_r  <= 1'b1;
         is_write_r <= 1'b0;
         addr_r     <= 8'h00;
         wdata_r    <= 8'h00;
         reply_r    <= 8'h00;
         we_r       <= 1'b0;
         re_r       <= 1'b0;
         ferr_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nx;
         rx_prev_r  <= rxDone;
         is_write_r <= is_write_nx;
         addr_r     <= addr_nx;
         wdata_r    <= wdata_nx;
         reply_r    <= reply_nx;
         we_r       <= (state_nx == ST_DO_WRITE);
         re_r       <= (state_nx == ST_DO_READ);
         ferr_r     <= ferr_nx;
         busy_r     <= (state_nx != ST_IDLE);
      end
   end

   // Inter-byte idle counter: runs only mid-frame, clears on each byte, saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (waiting_s && !byte_ev_s && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else if (waiting_s && !byte_ev_s) begin
         cnt_r <= cnt_r;
      end else begin
         cnt_r <= {CNT_W{1'b0}};
      end
   end

   // txStart depends on txBusy in the same cycle so a free transmitter is used immediately.
   assign txStart  = (state_r == ST_SEND) && !txBusy;
   assign txData   = reply_r;
   assign regWe    = we_r;
   assign regRe    = re_r;
   assign regAddr  = addr_r;
   assign regWdata = wdata_r;
   assign frameErr = ferr_r;
   assign busy     = busy_r;
endmodule
